// File: rtl/csa_resolve_adder.sv
// Resolves a CSA sum/carry pair into one binary word, CHUNK bits per cycle with a held carry.
// One pair in flight: result valid NCHUNK cycles after accept, held in DONE until out_ready.
module csa_resolve_adder #(
  parameter int WIDTH  = 55,
  parameter int CWIDTH = 53,
  parameter int CHUNK  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WIDTH-1:0]  sum_vec,
  input  logic [CWIDTH-1:0] carry_vec,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WIDTH-1:0]  result,
  output logic              cout
);
  localparam int NCHUNK = (WIDTH + CHUNK - 1) / CHUNK;
  localparam int LASTW  = WIDTH - (NCHUNK - 1) * CHUNK;
  localparam int CNTW   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [CNTW-1:0] LAST_CNT = CNTW'(NCHUNK - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             carry_q, carry_d;
  logic             cout_q, cout_d;
  logic [CNTW-1:0]  cnt_q, cnt_d;

  logic [31:0]      base;
  logic [CHUNK-1:0] a_ch, b_ch;
  logic [CHUNK:0]   ch_sum;
  logic             last_chunk;
  logic             ch_cout;
  logic [WIDTH-1:0] ch_mask, ch_bits;

  // The final chunk may be narrower than CHUNK; operand bits above WIDTH shift in as zero,
  // so the carry out of a partial chunk sits at bit LASTW of the chunk sum.
  always_comb begin
    base       = 32'(cnt_q) * 32'(CHUNK);
    a_ch       = CHUNK'(a_q >> base);
    b_ch       = CHUNK'(b_q >> base);
    ch_sum     = {1'b0, a_ch} + {1'b0, b_ch} + {{CHUNK{1'b0}}, carry_q};
    last_chunk = (cnt_q == LAST_CNT);
    ch_cout    = last_chunk ? ch_sum[LASTW] : ch_sum[CHUNK];
    ch_mask    = WIDTH'({CHUNK{1'b1}}) << base;
    ch_bits    = WIDTH'(ch_sum[CHUNK-1:0]) << base;
  end

  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    carry_d  = carry_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    cout_d   = cout_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          a_d      = sum_vec;
          b_d      = WIDTH'(carry_vec);
          carry_d  = 1'b0;
          cnt_d    = '0;
          result_d = '0;
          cout_d   = 1'b0;
          state_d  = S_RUN;
        end
      end
      S_RUN: begin
        result_d = (result_q & ~ch_mask) | ch_bits;
        carry_d  = ch_cout;
        if (last_chunk) begin
          cout_d  = ch_cout;
          cnt_d   = '0;
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q + CNTW'(1);
        end
      end
      S_DONE: begin
        if (out_ready) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      a_q      <= '0;
      b_q      <= '0;
      carry_q  <= 1'b0;
      cnt_q    <= '0;
      result_q <= '0;
      cout_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      carry_q  <= carry_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
      cout_q   <= cout_d;
    end
  end

  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = (state_q == S_DONE);
  assign result    = result_q;
  assign cout      = cout_q;

endmodule

// File: tb/tb_csa_resolve_adder.sv
// Bench for csa_resolve_adder: directed cases on the CHUNK=8 lane, random CSA-tree
// operands on lanes with CHUNK 1, 8, 13 and 55, results checked through a scoreboard queue.
module tb_csa_resolve_adder;
  localparam int W  = 55;
  localparam int CW = 53;
  localparam int NL = 4;
  localparam int M  = 1;
  localparam int NRAND = 300;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [NL-1:0] in_valid = '0;
  logic [NL-1:0] in_ready;
  logic [NL-1:0] out_valid;
  logic [NL-1:0] out_ready = '1;
  logic [NL-1:0] cout;
  logic [W-1:0]  result [NL];
  logic [W-1:0]  sum_vec = '0;
  logic [CW-1:0] carry_vec = '0;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int rand_base = 0;
  logic [55:0] exp_q[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  for (genvar g = 0; g < NL; g++) begin : g_lane
    localparam int C = (g == 0) ? 1 : (g == 1) ? 8 : (g == 2) ? 13 : 55;
    int n_out = 0;
    int hs_cyc = 0;
    int idx;

    csa_resolve_adder #(.WIDTH(W), .CWIDTH(CW), .CHUNK(C)) u_dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid[g]),
      .in_ready  (in_ready[g]),
      .sum_vec   (sum_vec),
      .carry_vec (carry_vec),
      .out_valid (out_valid[g]),
      .out_ready (out_ready[g]),
      .result    (result[g]),
      .cout      (cout[g])
    );

    always @(negedge clk) begin
      if (rst_n && out_valid[g] && out_ready[g]) begin
        idx = ((g == M) ? 0 : rand_base) + n_out;
        if (idx < exp_q.size())
          check_eq($sformatf("res_l%0d_n%0d", g, n_out), {cout[g], result[g]}, exp_q[idx]);
        else
          check_eq($sformatf("extra_out_l%0d", g), 64'(idx), 64'(exp_q.size()));
        n_out++;
        hs_cyc = cyc + 1;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic accept_m(input logic [W-1:0] s, input logic [CW-1:0] c, input bit keep,
                          output int t);
    sum_vec = s;
    carry_vec = c;
    in_valid[M] = 1'b1;
    t = -1;
    for (int i = 0; i < 100; i++) begin
      if (in_ready[M]) begin
        exp_q.push_back({1'b0, s} + {3'b0, c});
        tick();
        t = cyc;
        break;
      end
      tick();
    end
    if (!keep) in_valid[M] = 1'b0;
    if (t < 0) check_eq("accept_timeout", 64'(in_ready[M]), 64'd1);
  endtask

  task automatic wait_out(output int t);
    t = -1;
    for (int i = 0; i < 100; i++) begin
      if (out_valid[M]) begin
        t = cyc;
        break;
      end
      tick();
    end
    if (t < 0) check_eq("out_valid_timeout", 64'(out_valid[M]), 64'd1);
  endtask

  function automatic bit all_out(input int tgt_m, input int tgt_o);
    return g_lane[0].n_out >= tgt_o && g_lane[1].n_out >= tgt_m &&
           g_lane[2].n_out >= tgt_o && g_lane[3].n_out >= tgt_o;
  endfunction

  // Wallace-style 3:2 reduction of the 32 partial products of x*y down to two rows.
  function automatic void csa_tree(input logic [31:0] x, input logic [31:0] y,
                                   output logic [63:0] s, output logic [63:0] c);
    logic [63:0] rows[$];
    logic [63:0] a, b, d;
    for (int i = 0; i < 32; i++) rows.push_back(y[i] ? (64'(x) << i) : 64'd0);
    while (rows.size() > 2) begin
      a = rows.pop_front();
      b = rows.pop_front();
      d = rows.pop_front();
      rows.push_back(a ^ b ^ d);
      rows.push_back(((a & b) | (a & d) | (b & d)) << 1);
    end
    s = rows[0];
    c = rows[1];
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time %0t exceeded limit", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int t0, t1, t2;
    logic [63:0] s64, c64;
    logic [W-1:0] s55;
    logic [CW-1:0] c53;

    repeat (3) tick();
    check_eq("rst_in_ready", 64'(in_ready[M]), 64'd1);
    check_eq("rst_out_valid", 64'(out_valid[M]), 64'd0);
    check_eq("rst_result", 64'(result[M]), 64'd0);
    check_eq("rst_cout", 64'(cout[M]), 64'd0);
    rst_n = 1'b1;
    tick();

    // 1: latency and return to idle
    accept_m(55'h1, 53'h0, 1'b0, t0);
    wait_out(t1);
    check_eq("lat_t1", 64'(t1 - t0), 64'd7);
    tick();
    check_eq("t1_idle_rdy", 64'(in_ready[M]), 64'd1);
    check_eq("t1_idle_vld", 64'(out_valid[M]), 64'd0);

    // 2: carry ripples through every chunk
    accept_m(55'h7F_FFFF_FFFF_FFFF, 53'h2, 1'b0, t0);
    wait_out(t1);
    check_eq("lat_t2", 64'(t1 - t0), 64'd7);
    tick();

    // 3: backpressure in DONE with in_valid held high
    out_ready[M] = 1'b0;
    accept_m(55'h12_3456_789A_BCDE, 53'h0_0000_1111_1110, 1'b1, t0);
    wait_out(t1);
    for (int i = 0; i < 5; i++) begin
      check_eq($sformatf("bp_result_%0d", i), 64'(result[M]), 64'h12_3456_89AB_CDEE);
      check_eq($sformatf("bp_cout_%0d", i), 64'(cout[M]), 64'd0);
      check_eq($sformatf("bp_in_ready_%0d", i), 64'(in_ready[M]), 64'd0);
      check_eq($sformatf("bp_out_valid_%0d", i), 64'(out_valid[M]), 64'd1);
      tick();
    end
    in_valid[M] = 1'b0;
    out_ready[M] = 1'b1;
    tick();
    check_eq("bp_drop_vld", 64'(out_valid[M]), 64'd0);
    check_eq("bp_n_out", 64'(g_lane[M].n_out), 64'd3);

    // 4: reset on the third RUN cycle discards the transaction
    accept_m(55'h1234_5678, 53'h0, 1'b0, t0);
    tick();
    tick();
    rst_n = 1'b0;
    #1;
    check_eq("mid_rst_vld", 64'(out_valid[M]), 64'd0);
    check_eq("mid_rst_result", 64'(result[M]), 64'd0);
    check_eq("mid_rst_cout", 64'(cout[M]), 64'd0);
    void'(exp_q.pop_back());
    tick();
    rst_n = 1'b1;
    tick();
    check_eq("post_rst_rdy", 64'(in_ready[M]), 64'd1);
    check_eq("post_rst_vld", 64'(out_valid[M]), 64'd0);
    accept_m(55'h5, 53'h6, 1'b0, t0);
    wait_out(t1);
    check_eq("post_rst_result", 64'(result[M]), 64'hB);
    tick();

    // 5: back-to-back with in_valid held high
    accept_m(55'h0A_BCDE_F012_3456, 53'h1F_FFFF_0000_FFFE, 1'b1, t0);
    accept_m(55'h40_0000_0000_0001, 53'h10_0000_0000_0002, 1'b1, t2);
    in_valid[M] = 1'b0;
    check_eq("b2b_ii", 64'(t2 - t0), 64'd9);
    check_eq("b2b_after_hs", 64'(t2), 64'(g_lane[M].hs_cyc + 1));
    wait_out(t1);
    check_eq("lat_t5", 64'(t1 - t2), 64'd7);
    tick();
    tick();
    check_eq("dir_n_out", 64'(g_lane[M].n_out), 64'(exp_q.size()));

    // 6: random CSA-tree operands on every lane in lockstep
    rand_base = exp_q.size();
    for (int n = 0; n < NRAND; n++) begin
      csa_tree($urandom, $urandom, s64, c64);
      s55 = s64[W-1:0];
      c53 = c64[CW-1:0];
      sum_vec = s55;
      carry_vec = c53;
      in_valid = '1;
      exp_q.push_back({1'b0, s55} + {3'b0, c53});
      tick();
      in_valid = '0;
      for (int i = 0; i < 200 && !all_out(exp_q.size(), exp_q.size() - rand_base); i++) tick();
      tick();
      if (!all_out(exp_q.size(), exp_q.size() - rand_base)) begin
        check_eq("rand_timeout", 64'(g_lane[0].n_out), 64'(exp_q.size() - rand_base));
        break;
      end
    end

    check_eq("cnt_l0", 64'(g_lane[0].n_out), 64'(exp_q.size() - rand_base));
    check_eq("cnt_l1", 64'(g_lane[1].n_out), 64'(exp_q.size()));
    check_eq("cnt_l2", 64'(g_lane[2].n_out), 64'(exp_q.size() - rand_base));
    check_eq("cnt_l3", 64'(g_lane[3].n_out), 64'(exp_q.size() - rand_base));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
